// File: rtl/regfile_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_pkg
// Shared types and constants for the register-file write arbiter slice.
//   REG_W    : register address width
//   DATA_W   : register data width
//   NUM_REGS : number of architectural registers (width of the pending map)
//   REG_ZERO : hard-wired zero register; writes to it are dropped
//   wb_entry : one queued write-back {dest, data}
// -----------------------------------------------------------------------------
package regfile_write_arbiter_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // The destination field is called dest because "reg" is a keyword.
    typedef struct packed {
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] data;
    } wb_entry;

endpackage

// File: rtl/regfile_write_arbiter_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Dual-push, single-pop in-order FIFO of write-back entries.
//   clk, rst_n          : clock, asynchronous active-low reset
//   push0 / push0Entry  : first-ordered write port (MEM path)
//   push1 / push1Entry  : second-ordered write port (ALU path)
//   pop                 : remove the head (caller guarantees level != 0)
//   headEntry           : current head entry (valid when level != 0)
//   level               : occupancy, 0..DEPTH
//   entryValid/entryDest: per-slot occupancy and destination, for the
//                         pending-register scoreboard
// -----------------------------------------------------------------------------
module wb_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push0,
    input  wb_entry                     push0Entry,
    input  logic                        push1,
    input  wb_entry                     push1Entry,
    input  logic                        pop,
    output wb_entry                     headEntry,
    output logic [CNT_W-1:0]            level,
    output logic [DEPTH-1:0]            entryValid,
    output logic [DEPTH-1:0][REG_W-1:0] entryDest
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry          mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] wrPtrPlus1;

    assign wrPtrPlus1 = wrPtr + PTR_W'(1);

    // NOTE: storage has no reset; slot contents are only observed through
    // entryValid/level, which are reset, so clearing the array buys nothing.
    always_ff @(posedge clk) begin
        if (push0) begin
            mem[wrPtr] <= push0Entry;
        end
        // When both push, port 1 lands behind port 0 to preserve order.
        if (push1) begin
            mem[push0 ? wrPtrPlus1 : wrPtr] <= push1Entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr <= '0;
            wrPtr <= '0;
            level <= '0;
        end else begin
            wrPtr <= wrPtr + PTR_W'(push0) + PTR_W'(push1);
            rdPtr <= rdPtr + PTR_W'(pop);
            level <= level + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
        end
    end

    assign headEntry = mem[rdPtr];

    // A slot is live when its distance from the read pointer is below level.
    for (genvar i = 0; i < DEPTH; i++) begin : gEntry
        logic [PTR_W-1:0] offs;
        assign offs          = PTR_W'(i) - rdPtr;
        assign entryValid[i] = CNT_W'(offs) < level;
        assign entryDest[i]  = mem[i].dest;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Merges MEM-path and ALU-path write-backs into the single register-file write
// port through an in-order FIFO and a registered output stage, and exports a
// pending-destination map for hazard detection.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   mem_valid/mem_ready/reg/data   : MEM-path request handshake
//   alu_valid/alu_ready/reg/data   : ALU-path request handshake
//   RegWrite/WriteRegister/WriteData : registered register-file write port
//   pending                        : bit r set while a write to r is queued or
//                                    being issued (bit 0 always clear)
//   level                          : FIFO occupancy
//   drained                        : FIFO empty and output stage idle
// -----------------------------------------------------------------------------
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [4:0]        mem_reg,
    input  logic [31:0]       mem_data,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [4:0]        alu_reg,
    input  logic [31:0]       alu_data,
    output logic              RegWrite,
    output logic [4:0]        WriteRegister,
    output logic [31:0]       WriteData,
    output logic [31:0]       pending,
    output logic [CNT_W-1:0]  level,
    output logic              drained
);

    logic [CNT_W-1:0]            freeSlots;
    logic                        memPush;
    logic                        aluPush;
    logic                        popHead;
    wb_entry                     headEntry;
    logic [DEPTH-1:0]            entryValid;
    logic [DEPTH-1:0][REG_W-1:0] entryDest;
    logic [NUM_REGS-1:0]         pendingVec;

    assign freeSlots = CNT_W'(DEPTH) - level;

    // ALU must leave room for MEM whenever MEM is also requesting, since MEM
    // is enqueued first on a shared edge.
    assign mem_ready = freeSlots >= CNT_W'(1);
    assign alu_ready = mem_valid ? (freeSlots >= CNT_W'(2))
                                 : (freeSlots >= CNT_W'(1));

    // Register-0 writes complete the handshake but are never queued.
    assign memPush = mem_valid && mem_ready && (mem_reg != REG_ZERO);
    assign aluPush = alu_valid && alu_ready && (alu_reg != REG_ZERO);
    assign popHead = level != '0;

    wb_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) uFifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push0      (memPush),
        .push0Entry ('{dest: mem_reg, data: mem_data}),
        .push1      (aluPush),
        .push1Entry ('{dest: alu_reg, data: alu_data}),
        .pop        (popHead),
        .headEntry  (headEntry),
        .level      (level),
        .entryValid (entryValid),
        .entryDest  (entryDest)
    );

    // Output stage: one write per cycle, address/data hold while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else if (popHead) begin
            RegWrite      <= 1'b1;
            WriteRegister <= headEntry.dest;
            WriteData     <= headEntry.data;
        end else begin
            RegWrite      <= 1'b0;
        end
    end

    // NOTE: defaulting pendingVec before the loop keeps this block purely
    // combinational; a missing default would infer a latch.
    always_comb begin
        pendingVec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entryValid[i]) begin
                pendingVec = pendingVec | (NUM_REGS'(1) << entryDest[i]);
            end
        end
        if (RegWrite) begin
            pendingVec = pendingVec | (NUM_REGS'(1) << WriteRegister);
        end
        pendingVec[0] = 1'b0;
    end

    assign pending = pendingVec;
    assign drained = (level == '0) && !RegWrite;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
// Scoreboard bench: a queue-based reference model predicts handshakes,
// occupancy, the pending map and the write port every cycle, and a separate
// monitor matches every RegWrite pulse against the queue of accepted writes.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

    import regfile_write_arbiter_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             mem_valid = 1'b0;
    logic             mem_ready;
    logic [4:0]       mem_reg = '0;
    logic [31:0]      mem_data = '0;
    logic             alu_valid = 1'b0;
    logic             alu_ready;
    logic [4:0]       alu_reg = '0;
    logic [31:0]      alu_data = '0;
    logic             RegWrite;
    logic [4:0]       WriteRegister;
    logic [31:0]      WriteData;
    logic [31:0]      pending;
    logic [CNT_W-1:0] level;
    logic             drained;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_reg       (mem_reg),
        .mem_data      (mem_data),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_reg       (alu_reg),
        .alu_data      (alu_data),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .pending       (pending),
        .level         (level),
        .drained       (drained)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } req_t;

    req_t        modelQ[$];   // writes waiting in the FIFO
    req_t        expQ[$];     // scoreboard: every accepted write, in order
    bit          outValid = 1'b0;
    logic [4:0]  outReg = '0;
    logic [31:0] outData = '0;
    bit          modelOn = 1'b0;

    // Model state describes the DUT after the most recent edge; it is compared
    // mid-cycle and then advanced across the coming edge.
    always @(negedge clk) begin : modelBlk
        int          freeN;
        bit          expMemR;
        bit          expAluR;
        logic [31:0] expPend;
        req_t        head;
        if (rst_n && modelOn) begin
            freeN   = DEPTH - modelQ.size();
            expMemR = freeN >= 1;
            expAluR = mem_valid ? (freeN >= 2) : (freeN >= 1);
            expPend = '0;
            foreach (modelQ[i]) expPend[modelQ[i].r] = 1'b1;
            if (outValid) expPend[outReg] = 1'b1;
            expPend[0] = 1'b0;

            check("mem_ready", 32'(mem_ready), 32'(expMemR));
            check("alu_ready", 32'(alu_ready), 32'(expAluR));
            check("level", 32'(level), 32'(modelQ.size()));
            check("no_overflow", 32'(level <= CNT_W'(DEPTH)), 32'd1);
            check("pending", pending, expPend);
            check("drained", 32'(drained), 32'(modelQ.size() == 0 && !outValid));
            check("RegWrite", 32'(RegWrite), 32'(outValid));
            check("WriteRegister", 32'(WriteRegister), 32'(outReg));
            check("WriteData", WriteData, outData);

            if (modelQ.size() > 0) begin
                head     = modelQ.pop_front();
                outValid = 1'b1;
                outReg   = head.r;
                outData  = head.d;
            end else begin
                outValid = 1'b0;
            end
            if (mem_valid && expMemR && mem_reg != 5'd0) begin
                modelQ.push_back('{r: mem_reg, d: mem_data});
                expQ.push_back('{r: mem_reg, d: mem_data});
            end
            if (alu_valid && expAluR && alu_reg != 5'd0) begin
                modelQ.push_back('{r: alu_reg, d: alu_data});
                expQ.push_back('{r: alu_reg, d: alu_data});
            end
        end
    end

    // ---------------- write-port monitor ----------------
    always @(negedge clk) begin : monBlk
        req_t e;
        if (rst_n && modelOn && RegWrite) begin
            if (expQ.size() == 0) begin
                check("spurious_write", 32'(RegWrite), 32'd0);
            end else begin
                e = expQ.pop_front();
                check("sb_reg", 32'(WriteRegister), 32'(e.r));
                check("sb_data", WriteData, e.d);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit mv, input logic [4:0] mr, input logic [31:0] md,
                         input bit av, input logic [4:0] ar, input logic [31:0] ad);
        @(posedge clk);
        #1;
        mem_valid = mv; mem_reg = mr; mem_data = md;
        alu_valid = av; alu_reg = ar; alu_data = ad;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state while rst_n is held low.
        repeat (2) @(posedge clk);
        #1;
        check("rst_RegWrite", 32'(RegWrite), 32'd0);
        check("rst_WriteRegister", 32'(WriteRegister), 32'd0);
        check("rst_WriteData", WriteData, 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_pending", pending, 32'd0);
        check("rst_drained", 32'(drained), 32'd1);
        #2;
        rst_n   = 1'b1;
        modelOn = 1'b1;

        // Single write.
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
        idle(4);

        // Dual write to the same register: MEM value first, ALU value final.
        drive(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
        idle(4);

        // Back-pressure with both sources always requesting.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 5'((2 * i) % 31 + 1), 32'hA000_0000 + 32'(i),
                  1'b1, 5'((2 * i + 1) % 31 + 1), 32'hB000_0000 + 32'(i));
        end
        idle(6);

        // Register 0: handshake completes, nothing is queued.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        idle(3);

        // Reset in the middle of a busy period.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(i + 10), 32'hC000_0000 + 32'(i),
                  1'b1, 5'(i + 20), 32'hD000_0000 + 32'(i));
        end
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        modelQ.delete();
        expQ.delete();
        outValid = 1'b0;
        outReg   = '0;
        outData  = '0;
        #1;
        check("async_RegWrite", 32'(RegWrite), 32'd0);
        check("async_WriteRegister", 32'(WriteRegister), 32'd0);
        check("async_WriteData", WriteData, 32'd0);
        check("async_level", 32'(level), 32'd0);
        check("async_pending", pending, 32'd0);
        check("async_drained", 32'(drained), 32'd1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle(4);

        // Continuous traffic across several pointer wraps.
        for (int i = 0; i < 3 * DEPTH; i++) begin
            drive(1'b1, 5'(i % 31 + 1), 32'h0000_1000 + 32'(i), 1'b0, 5'd0, 32'd0);
        end
        idle(4);

        // Random traffic, register 0 included.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom);
        end
        idle(10);

        check("scoreboard_empty", 32'(expQ.size()), 32'd0);
        check("final_drained", 32'(drained), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
